dds_dac_streamer: RTL and testbench
===================================

# dds_dac_streamer

Sink end of the shaping block's DDS output stream. Accepts valid-qualified 32-bit DDS words (cosine in [31:16], sine in [15:0]) and buffers them in a small FIFO. Each word is converted from two's complement to offset binary and serialized as two 24-bit frames (channel A = [15:0], channel B = [31:16]) to a serial dual-channel DAC. The FIFO is flushed on every change of the mode-select vector so stale samples from the previous mode never reach the DAC.

## Interface
- FIFO_DEPTH, 16: sample FIFO depth; power of two, 4..64.
- SCLK_DIV, 4: GCLK cycles per DAC_SCLK half-period; ≥ 2.
- DAC_CMD, 4'b0011: 4-bit command nibble placed in frame bits [23:20].

Ports:
- GCLK  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- DDS_IN  in  32  DDS word, {cos[15:0], sin[15:0]}, two's complement.
- DDS_IN_VALID  in  1  DDS_IN valid this cycle; no backpressure.
- MOD_SEL  in  4  current mode vector; any change triggers a flush.
- DAC_SCLK  out  1  serial clock; idles low.
- DAC_SYNC_N  out  1  frame strobe, active low.
- DAC_DIN  out  1  serial data, MSB first.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- OVERFLOW  out  1  sticky; set when a valid word is dropped.
- BUSY  out  1  high while a sample (frame A + frame B) is in flight.

## Operation
- **Reset values:** DAC_SCLK=0, DAC_SYNC_N=1, DAC_DIN=0, FIFO_LEVEL=0, OVERFLOW=0, BUSY=0, FSM=IDLE, MOD_SEL history register = MOD_SEL.
- **Write:** a word is accepted when DDS_IN_VALID=1 and either (level < FIFO_DEPTH) or a pop happens in the same cycle.
- **Overflow:** when a word is not accepted, it is dropped and OVERFLOW is set. OVERFLOW clears only on reset.
- **Frame format:** 24 bits, {DAC_CMD, 3'b000, ch, data[15:0]}. ch=0 for A, ch=1 for B. Data = sample with its MSB inverted (two's complement to offset binary).
- **FSM states:**
  - IDLE: go to LOAD when level > 0.
  - LOAD: pop one word; latch both channel words; load frame A into a 24-bit shifter; set BUSY.
  - SHIFT: 24 bit periods.
  - GAP: 2·SCLK_DIV cycles with SYNC_N high. After frame A, GAP goes to SHIFT with frame B loaded. After frame B, GAP goes to LOAD if level > 0, else to IDLE; BUSY drops on leaving GAP after frame B.
- **Flush:** MOD_SEL ≠ history register triggers a flush.
  - On that cycle the FIFO pointers and level clear, and any write in that cycle is discarded (does not set OVERFLOW).
  - The history register updates.
  - A sample already latched (BUSY=1) completes both frames.
- **Simultaneous write, pop and flush:** flush wins; FIFO_LEVEL=0 on the next cycle.
- **Reset mid-frame:** all outputs return to their reset values at the next GCLK edge; no partial-frame completion.

## Timing
- **Latency:** word accepted at edge E0 into an empty FIFO in IDLE → FIFO_LEVEL=1 after E0, LOAD after E0+1, DAC_SYNC_N=0 and DAC_DIN=bit 23 after E0+2.
- **Bit period:** each bit is DAC_SCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles. DAC_DIN changes only at the edge where SCLK goes low (or at SYNC_N fall for bit 23). The DAC samples on the SCLK rising edge.
- **Frame end:** after the 24th high phase, SCLK returns low and DAC_SYNC_N rises on the same edge.
- **Frame length:** SYNC_N low for 48·SCLK_DIV cycles.
- **Sample period:** 2·(48+2)·SCLK_DIV cycles, i.e. 400 cycles at the default SCLK_DIV=4. Sustained input rate above this overflows.
- **FIFO_LEVEL:** registered; reflects writes, pops and flush one cycle after the event.

## Structure
- Shared package dds_dac_pkg:
  - frame width (24) and field positions;
  - default DAC_CMD;
  - FSM state enum {IDLE, LOAD, SHIFT, GAP};
  - channel select constants.
- Sub-module dds_sample_fifo: synchronous, 32-bit wide, FIFO_DEPTH deep. Ports: wr_en, wr_data, rd_en, rd_data, flush, level, full, empty; first-word read data valid on the cycle after rd_en.
- Top level contains the flush detector, the FSM, the SCLK divider counter, the bit counter and the shifter.

## Test plan
- **Single word:** DDS_IN=32'h8000_7FFF pulse in IDLE.
  - SYNC_N falls 2 cycles later.
  - Frame A bits = 0x30_FFFF; frame B bits = 0x31_0000.
  - 192 cycles SYNC_N low per frame, 8-cycle gap; BUSY high throughout, then low.
- **Overflow:** 17 back-to-back valid words with FIFO_DEPTH=16 and the first word still queued (no pop yet).
  - FIFO_LEVEL=16.
  - Word 17 dropped; OVERFLOW=1 and stays 1 until reset.
- **Flush mid-sample:** 4 words queued; MOD_SEL changes 4'b0001→4'b0010 during frame A of word 1.
  - Word 1 completes both frames.
  - FIFO_LEVEL=0 next cycle; FSM returns to IDLE; no further frames.
- **Reset mid-frame:** reset asserted at bit 10 of frame B.
  - Next cycle SYNC_N=1, SCLK=0, DIN=0, BUSY=0, FIFO_LEVEL=0.
- **Write + flush same cycle:** valid word coincident with a MOD_SEL change.
  - Word discarded; OVERFLOW stays 0; FIFO_LEVEL=0.
- **Sustained stream:** valid every 400 cycles for 50 words.
  - No overflow; FIFO_LEVEL ≤ 1; 100 frames, each with correct channel bit and inverted MSB.

Source files
------------

// File: rtl/dds_dac_pkg.sv
// Shared types, frame layout and helpers for the DDS-to-DAC serial streamer.
package dds_dac_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FRAME_W = 24;
  localparam int unsigned CMD_MSB = 23;
  localparam int unsigned CMD_LSB = 20;
  localparam int unsigned CH_BIT  = 16;

  localparam logic [3:0] DAC_CMD_DEFAULT = 4'b0011;
  localparam logic       CH_A            = 1'b0;
  localparam logic       CH_B            = 1'b1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} dac_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] cos;
    logic [DATA_W-1:0] sin;
  } dds_word_t;

  // Build one DAC frame; the inverted sample MSB turns two's complement into offset binary.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [3:0] cmd, input logic ch,
                                                    input logic [DATA_W-1:0] sample);
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[CMD_MSB:CMD_LSB]   = cmd;
    f[CH_BIT]            = ch;
    f[DATA_W-1:0]        = {~sample[DATA_W-1], sample[DATA_W-2:0]};
    return f;
  endfunction

endpackage

// File: rtl/dds_dac_streamer_if.sv
// Valid-qualified DDS sample stream into the DAC streamer (no backpressure).
interface dds_dac_streamer_if;
  import dds_dac_pkg::*;

  dds_word_t DDS_IN;
  logic      DDS_IN_VALID;

  modport master (output DDS_IN, output DDS_IN_VALID);
  modport slave  (input  DDS_IN, input  DDS_IN_VALID);
endinterface

// File: rtl/dds_sample_fifo.sv
// Synchronous sample FIFO with flush; read data is registered one cycle after rd_en.
module dds_sample_fifo import dds_dac_pkg::*; #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     GCLK,
   input  logic                     reset,
   input  logic                     wr_en,
   input  dds_word_t                wr_data,
   input  logic                     rd_en,
   output dds_word_t                rd_data,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   dds_word_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     level_nxt;

   // Flush dominates any write or read in the same cycle.
   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (wr_en && !rd_en)
         level_nxt = level + (AW+1)'(1);
      else if (rd_en && !wr_en)
         level_nxt = level - (AW+1)'(1);
   end

   always_ff @(posedge GCLK) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         rd_data <= '0;
      end else begin
         level <= level_nxt;
         full  <= (level_nxt == (AW+1)'(DEPTH));
         empty <= (level_nxt == '0);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en)
               wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
               rd_ptr  <= rd_ptr + AW'(1);
               rd_data <= mem[rd_ptr];
            end
         end
      end
   end

   always_ff @(posedge GCLK) begin
      if (wr_en && !flush)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/dds_dac_streamer.sv
// Buffers DDS words and serializes each as two 24-bit offset-binary frames to a dual-channel DAC.
module dds_dac_streamer import dds_dac_pkg::*; #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned SCLK_DIV   = 4,
   parameter logic [3:0]  DAC_CMD    = DAC_CMD_DEFAULT
) (
   input  logic                          GCLK,
   input  logic                          reset,
   dds_dac_streamer_if.slave             dds,
   input  logic [3:0]                    MOD_SEL,
   output logic                          DAC_SCLK,
   output logic                          DAC_SYNC_N,
   output logic                          DAC_DIN,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          OVERFLOW,
   output logic                          BUSY
);

   localparam int unsigned GAP_LEN = 2 * SCLK_DIV;
   localparam int unsigned CNT_W   = $clog2(GAP_LEN);
   localparam int unsigned BIT_W   = $clog2(FRAME_W);

   dac_state_e          state;
   logic [3:0]          mod_hist;
   logic [CNT_W-1:0]    cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [FRAME_W-1:0]  shifter;
   logic [DATA_W-1:0]   ch_b_data;
   logic                frame_b;

   logic                flush;
   logic                start_ok;
   logic                rd_en;
   logic                wr_en;
   logic                drop;
   logic                fifo_full;
   logic                fifo_empty;
   dds_word_t           rd_data;
   logic [FRAME_W-1:0]  frame_a_c;
   logic [FRAME_W-1:0]  frame_b_c;

   assign flush     = (MOD_SEL != mod_hist);
   assign start_ok  = !fifo_empty && !flush;
   assign wr_en     = dds.DDS_IN_VALID && !flush && (!fifo_full || rd_en);
   assign drop      = dds.DDS_IN_VALID && !flush && !wr_en;
   assign frame_a_c = make_frame(DAC_CMD, CH_A, rd_data.sin);
   assign frame_b_c = make_frame(DAC_CMD, CH_B, ch_b_data);

   // Pop on the way into LOAD so the registered read data is ready inside LOAD.
   always_comb begin
      rd_en = 1'b0;
      case (state)
         IDLE:    rd_en = start_ok;
         GAP:     rd_en = frame_b && (cnt == CNT_W'(GAP_LEN - 2)) && start_ok;
         default: rd_en = 1'b0;
      endcase
   end

   dds_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .GCLK    (GCLK),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (dds.DDS_IN),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .flush   (flush),
      .level   (FIFO_LEVEL),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge GCLK) begin
      if (reset) begin
         state      <= IDLE;
         mod_hist   <= MOD_SEL;
         cnt        <= '0;
         bit_cnt    <= '0;
         shifter    <= '0;
         ch_b_data  <= '0;
         frame_b    <= 1'b0;
         DAC_SCLK   <= 1'b0;
         DAC_SYNC_N <= 1'b1;
         DAC_DIN    <= 1'b0;
         OVERFLOW   <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         mod_hist <= MOD_SEL;
         if (drop)
            OVERFLOW <= 1'b1;

         case (state)
            IDLE: begin
               if (rd_en)
                  state <= LOAD;
            end

            LOAD: begin
               shifter    <= frame_a_c;
               DAC_DIN    <= frame_a_c[FRAME_W-1];
               ch_b_data  <= rd_data.cos;
               frame_b    <= 1'b0;
               BUSY       <= 1'b1;
               DAC_SYNC_N <= 1'b0;
               DAC_SCLK   <= 1'b0;
               cnt        <= '0;
               bit_cnt    <= '0;
               state      <= SHIFT;
            end

            // Each bit: SCLK low for SCLK_DIV cycles, then high; data moves on the falling edge.
            SHIFT: begin
               if (cnt == CNT_W'(SCLK_DIV - 1)) begin
                  cnt <= '0;
                  if (!DAC_SCLK) begin
                     DAC_SCLK <= 1'b1;
                  end else begin
                     DAC_SCLK <= 1'b0;
                     if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                        DAC_SYNC_N <= 1'b1;
                        DAC_DIN    <= 1'b0;
                        state      <= GAP;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        shifter <= {shifter[FRAME_W-2:0], 1'b0};
                        DAC_DIN <= shifter[FRAME_W-2];
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Back-to-back samples borrow the last gap cycle for LOAD to keep the 8-cycle SYNC_N gap.
            GAP: begin
               cnt <= cnt + CNT_W'(1);
               if (!frame_b && (cnt == CNT_W'(GAP_LEN - 1))) begin
                  shifter    <= frame_b_c;
                  DAC_DIN    <= frame_b_c[FRAME_W-1];
                  DAC_SYNC_N <= 1'b0;
                  frame_b    <= 1'b1;
                  cnt        <= '0;
                  bit_cnt    <= '0;
                  state      <= SHIFT;
               end else if (frame_b && rd_en) begin
                  BUSY  <= 1'b0;
                  state <= LOAD;
               end else if (frame_b && (cnt == CNT_W'(GAP_LEN - 1))) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_dac_streamer.sv
// Self-checking bench for dds_dac_streamer: table vectors, corner-case sequences, random bursts.
module tb_dds_dac_streamer;
   import dds_dac_pkg::*;

   localparam int unsigned DIV       = 4;
   localparam int unsigned FRAME_CYC = 48 * DIV;
   localparam int unsigned GAP_CYC   = 2 * DIV;
   localparam int unsigned SAMPLE_CYC = 2 * (48 + 2) * DIV;
   localparam logic [3:0]  CMD_TB    = 4'b0011;

   logic       GCLK    = 1'b0;
   logic       reset   = 1'b1;
   logic [3:0] MOD_SEL = 4'b0001;
   logic       DAC_SCLK, DAC_SYNC_N, DAC_DIN, OVERFLOW, BUSY;
   logic [4:0] FIFO_LEVEL;

   dds_dac_streamer_if dif ();

   dds_dac_streamer #(.FIFO_DEPTH(16), .SCLK_DIV(DIV), .DAC_CMD(CMD_TB)) dut (
      .GCLK(GCLK), .reset(reset), .dds(dif), .MOD_SEL(MOD_SEL),
      .DAC_SCLK(DAC_SCLK), .DAC_SYNC_N(DAC_SYNC_N), .DAC_DIN(DAC_DIN),
      .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
   );

   typedef struct {
      logic [23:0] bits;
      int          nbits;
      int          start;
      int          stop;
   } frame_t;

   typedef struct {
      logic [31:0] word;
      logic [23:0] fa;
      logic [23:0] fb;
   } vec_t;

   frame_t frames[$];
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   int     busy_start = 0;
   int     busy_len = 0;
   int     max_level = 0;

   initial forever #5 GCLK = ~GCLK;
   initial forever begin @(posedge GCLK); cyc++; end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   // Serial-side monitor: rebuild frames from SCLK rising edges, track BUSY windows and level peak.
   initial begin
      logic        in_frame = 1'b0, prev_sclk = 1'b0, prev_busy = 1'b0;
      logic [23:0] cur = '0;
      int          nb = 0, fstart = 0, bcnt = 0;
      forever begin
         @(negedge GCLK);
         if (reset) begin
            in_frame = 1'b0; prev_sclk = 1'b0; prev_busy = 1'b0; bcnt = 0;
         end else begin
            if (!DAC_SYNC_N) begin
               if (!in_frame) begin in_frame = 1'b1; cur = '0; nb = 0; fstart = cyc; end
               if (DAC_SCLK && !prev_sclk) begin cur = {cur[22:0], DAC_DIN}; nb++; end
            end else if (in_frame) begin
               in_frame = 1'b0;
               frames.push_back(frame_t'{bits: cur, nbits: nb, start: fstart, stop: cyc});
            end
            if (BUSY && !prev_busy) begin busy_start = cyc; bcnt = 0; end
            if (BUSY) bcnt++;
            if (!BUSY && prev_busy) busy_len = bcnt;
            prev_sclk = DAC_SCLK;
            prev_busy = BUSY;
            if (int'(FIFO_LEVEL) > max_level) max_level = int'(FIFO_LEVEL);
         end
      end
   end

   // Reference: offset binary = sample + 2^15 mod 2^16, framed with command and channel.
   function automatic logic [23:0] exp_frame(input logic [31:0] w, input int unsigned ch);
      int unsigned s, ob;
      s  = (ch == 1) ? 32'(w[31:16]) : 32'(w[15:0]);
      ob = (s + 32'd32768) % 32'd65536;
      return 24'((32'(CMD_TB) << 20) + (ch << 16) + ob);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send_word(input logic [31:0] w, output int c0, output int lvl);
      @(negedge GCLK);
      dif.DDS_IN = w;
      dif.DDS_IN_VALID = 1'b1;
      @(negedge GCLK);
      dif.DDS_IN_VALID = 1'b0;
      c0  = cyc;
      lvl = int'(FIFO_LEVEL);
   endtask

   task automatic get_frame(output frame_t f, input int limit);
      int n = 0;
      while (frames.size() == 0 && n < limit) begin @(negedge GCLK); n++; end
      if (frames.size() == 0) begin
         checks++; errors++;
         $display("FAIL frame_timeout: got none expected a frame within %0d cycles", limit);
         f = frame_t'{bits: '0, nbits: 0, start: 0, stop: 0};
      end else begin
         f = frames.pop_front();
      end
   endtask

   task automatic wait_busy_low(input int limit);
      int n = 0;
      while (BUSY && n < limit) begin @(negedge GCLK); n++; end
      chk("busy_low_timeout", 32'(BUSY), 32'd0);
      @(negedge GCLK);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge GCLK);
   endtask

   // Compare both frames of one sample, including frame length and A->B gap.
   task automatic check_sample(input string tag, input logic [23:0] fa, input logic [23:0] fb);
      frame_t a, b;
      get_frame(a, 2 * SAMPLE_CYC);
      get_frame(b, SAMPLE_CYC);
      chk({tag, "_frameA"}, 32'(a.bits), 32'(fa));
      chk({tag, "_frameB"}, 32'(b.bits), 32'(fb));
      chk({tag, "_nbitsA"}, a.nbits, 24);
      chk({tag, "_lenA"},   a.stop - a.start, FRAME_CYC);
      chk({tag, "_lenB"},   b.stop - b.start, FRAME_CYC);
      chk({tag, "_gapAB"},  b.start - a.stop, GAP_CYC);
   endtask

   vec_t vecs[5];

   initial begin
      int          c0, lvl, n;
      logic [31:0] w;
      logic [31:0] ws[4];
      logic [31:0] model[$];
      frame_t      fa, fb;

      vecs[0] = '{32'h8000_7FFF, 24'h30FFFF, 24'h310000};
      vecs[1] = '{32'h0000_0000, 24'h308000, 24'h318000};
      vecs[2] = '{32'hFFFF_FFFF, 24'h307FFF, 24'h317FFF};
      vecs[3] = '{32'h1234_ABCD, 24'h302BCD, 24'h319234};
      vecs[4] = '{32'h7FFF_8000, 24'h300000, 24'h31FFFF};

      dif.DDS_IN = '0;
      dif.DDS_IN_VALID = 1'b0;

      // Reset state
      wait_cycles(3);
      chk("rst_sclk",  32'(DAC_SCLK),   32'd0);
      chk("rst_sync",  32'(DAC_SYNC_N), 32'd1);
      chk("rst_din",   32'(DAC_DIN),    32'd0);
      chk("rst_level", 32'(FIFO_LEVEL), 32'd0);
      chk("rst_ovf",   32'(OVERFLOW),   32'd0);
      chk("rst_busy",  32'(BUSY),       32'd0);
      reset = 1'b0;
      wait_cycles(2);

      // Table-driven single words from IDLE: latency, frame content, timing, BUSY window
      for (int i = 0; i < 5; i++) begin
         send_word(vecs[i].word, c0, lvl);
         chk("vec_level_after_write", lvl, 1);
         get_frame(fa, SAMPLE_CYC);
         get_frame(fb, SAMPLE_CYC);
         chk("vec_frameA", 32'(fa.bits), 32'(vecs[i].fa));
         chk("vec_frameB", 32'(fb.bits), 32'(vecs[i].fb));
         chk("vec_model_A", 32'(fa.bits), 32'(exp_frame(vecs[i].word, 0)));
         chk("vec_latency", fa.start - c0, 2);
         chk("vec_nbits", fa.nbits + fb.nbits, 48);
         chk("vec_lenA", fa.stop - fa.start, FRAME_CYC);
         chk("vec_lenB", fb.stop - fb.start, FRAME_CYC);
         chk("vec_gap",  fb.start - fa.stop, GAP_CYC);
         wait_busy_low(GAP_CYC + 4);
         chk("vec_busy_start", busy_start, fa.start);
         chk("vec_busy_len", busy_len, SAMPLE_CYC);
      end

      // Flush mid-sample: 4 queued, MOD_SEL changes during frame A of word 1
      for (int k = 0; k < 4; k++) ws[k] = $urandom;
      for (int k = 0; k < 4; k++) begin
         @(negedge GCLK);
         dif.DDS_IN = ws[k];
         dif.DDS_IN_VALID = 1'b1;
      end
      @(negedge GCLK);
      dif.DDS_IN_VALID = 1'b0;
      n = 0;
      while (DAC_SYNC_N && n < 20) begin @(negedge GCLK); n++; end
      chk("flush_frame_started", 32'(DAC_SYNC_N), 32'd0);
      wait_cycles(20);
      chk("flush_level_before", 32'(FIFO_LEVEL), 32'd3);
      MOD_SEL = 4'b0010;
      @(negedge GCLK);
      chk("flush_level_after", 32'(FIFO_LEVEL), 32'd0);
      check_sample("flush_word1", exp_frame(ws[0], 0), exp_frame(ws[0], 1));
      wait_busy_low(GAP_CYC + 4);
      wait_cycles(SAMPLE_CYC + 100);
      chk("flush_no_more_frames", frames.size(), 0);
      chk("flush_idle_busy", 32'(BUSY), 32'd0);
      chk("flush_ovf", 32'(OVERFLOW), 32'd0);

      // Overflow: FSM busy, 17 back-to-back words into a 16-deep FIFO
      w = $urandom;
      send_word(w, c0, lvl);
      n = 0;
      while (!BUSY && n < 10) begin @(negedge GCLK); n++; end
      chk("ovf_busy", 32'(BUSY), 32'd1);
      for (int k = 0; k < 17; k++) begin
         @(negedge GCLK);
         if (k == 16) begin
            chk("ovf_level_16", 32'(FIFO_LEVEL), 32'd16);
            chk("ovf_not_yet", 32'(OVERFLOW), 32'd0);
         end
         dif.DDS_IN = $urandom;
         dif.DDS_IN_VALID = 1'b1;
      end
      @(negedge GCLK);
      dif.DDS_IN_VALID = 1'b0;
      chk("ovf_level_full", 32'(FIFO_LEVEL), 32'd16);
      chk("ovf_set", 32'(OVERFLOW), 32'd1);
      wait_cycles(50);
      chk("ovf_sticky", 32'(OVERFLOW), 32'd1);
      MOD_SEL = 4'b0100;
      @(negedge GCLK);
      chk("ovf_flush_level", 32'(FIFO_LEVEL), 32'd0);
      check_sample("ovf_word0", exp_frame(w, 0), exp_frame(w, 1));
      wait_busy_low(GAP_CYC + 4);
      wait_cycles(SAMPLE_CYC);
      chk("ovf_sticky_late", 32'(OVERFLOW), 32'd1);
      chk("ovf_no_more_frames", frames.size(), 0);

      // Reset during bit 10 of frame B, with a second word still queued
      for (int k = 0; k < 2; k++) begin
         @(negedge GCLK);
         dif.DDS_IN = $urandom;
         dif.DDS_IN_VALID = 1'b1;
      end
      @(negedge GCLK);
      dif.DDS_IN_VALID = 1'b0;
      get_frame(fa, SAMPLE_CYC);
      n = 0;
      while (DAC_SYNC_N && n < 20) begin @(negedge GCLK); n++; end
      begin
         int   rises = 0;
         logic ps = 1'b0;
         n = 0;
         while (rises < 10 && n < 400) begin
            @(negedge GCLK);
            if (DAC_SCLK && !ps) rises++;
            ps = DAC_SCLK;
            n++;
         end
         chk("rstmid_reached_bit10", rises, 10);
      end
      chk("rstmid_level_before", 32'(FIFO_LEVEL), 32'd1);
      reset = 1'b1;
      @(negedge GCLK);
      chk("rstmid_sync", 32'(DAC_SYNC_N), 32'd1);
      chk("rstmid_sclk", 32'(DAC_SCLK),   32'd0);
      chk("rstmid_din",  32'(DAC_DIN),    32'd0);
      chk("rstmid_busy", 32'(BUSY),       32'd0);
      chk("rstmid_level", 32'(FIFO_LEVEL), 32'd0);
      chk("rstmid_ovf",  32'(OVERFLOW),   32'd0);
      reset = 1'b0;
      wait_cycles(2);
      frames.delete();
      wait_cycles(2 * SAMPLE_CYC);
      chk("rstmid_no_frames", frames.size(), 0);

      // Valid word coincident with a MOD_SEL change is discarded silently
      @(negedge GCLK);
      dif.DDS_IN = $urandom;
      dif.DDS_IN_VALID = 1'b1;
      MOD_SEL = 4'b1000;
      @(negedge GCLK);
      dif.DDS_IN_VALID = 1'b0;
      chk("wrflush_level", 32'(FIFO_LEVEL), 32'd0);
      chk("wrflush_ovf", 32'(OVERFLOW), 32'd0);
      wait_cycles(50);
      chk("wrflush_busy", 32'(BUSY), 32'd0);
      chk("wrflush_no_frames", frames.size(), 0);

      // Sustained stream: one word every sample period for 50 words
      max_level = 0;
      model.delete();
      for (int k = 0; k < 50; k++) begin
         w = $urandom;
         model.push_back(w);
         @(negedge GCLK);
         dif.DDS_IN = w;
         dif.DDS_IN_VALID = 1'b1;
         @(negedge GCLK);
         dif.DDS_IN_VALID = 1'b0;
         wait_cycles(SAMPLE_CYC - 2);
      end
      while (model.size() > 0) begin
         w = model.pop_front();
         get_frame(fa, 2 * SAMPLE_CYC);
         get_frame(fb, SAMPLE_CYC);
         chk("stream_frameA", 32'(fa.bits), 32'(exp_frame(w, 0)));
         chk("stream_frameB", 32'(fb.bits), 32'(exp_frame(w, 1)));
      end
      wait_busy_low(2 * SAMPLE_CYC);
      chk("stream_ovf", 32'(OVERFLOW), 32'd0);
      chk("stream_max_level_le1", 32'(max_level <= 1), 32'd1);
      chk("stream_no_extra", frames.size(), 0);

      // Random bursts against the queue model
      for (int b = 0; b < 6; b++) begin
         int len;
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            w = $urandom;
            model.push_back(w);
            @(negedge GCLK);
            dif.DDS_IN = w;
            dif.DDS_IN_VALID = 1'b1;
            @(negedge GCLK);
            dif.DDS_IN_VALID = 1'b0;
            wait_cycles($urandom_range(0, 3));
         end
         while (model.size() > 0) begin
            w = model.pop_front();
            check_sample("rand", exp_frame(w, 0), exp_frame(w, 1));
         end
         wait_busy_low(GAP_CYC + 4);
      end
      chk("rand_ovf", 32'(OVERFLOW), 32'd0);
      chk("rand_level", 32'(FIFO_LEVEL), 32'd0);
      chk("rand_no_extra", frames.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
